// File: rtl/cim_epoch_sequencer.sv
// rtl/cim_epoch_sequencer.sv - SoC-side epoch loader, inference launcher and result returner for the CIM
module cim_epoch_sequencer #(
    parameter int NUM_SAMPLES    = 3000,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              cim_rst_n,
    output logic              new_sleep_epoch,
    input  logic              cim_inference_complete,
    input  logic [2:0]        cim_sleep_stage,
    output logic              result_valid,
    output logic [2:0]        result_stage,
    input  logic              result_ready,
    output logic              err_timeout,
    output logic              err_bad_stage,
    input  logic              err_clear,
    output logic [15:0]       epoch_count
);

    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT_INF,
        S_RESULT,
        S_ABORT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] sample_cnt;
    logic              start_done;
    logic [WD_W-1:0]   watchdog;
    logic [1:0]        abort_cnt;

    logic sample_hs;
    logic result_hs;
    logic last_sample;
    logic capture;

    // registered-output next values
    logic sample_ready_d;
    logic new_sleep_epoch_d;
    logic cim_rst_n_d;
    logic result_valid_d;
    logic set_timeout;
    logic set_bad_stage;

    assign sample_hs   = sample_valid & sample_ready;
    assign result_hs   = result_valid & result_ready;
    assign last_sample = sample_hs && (sample_cnt == LAST_ADDR);
    assign capture     = (state == S_WAIT_INF) && cim_inference_complete;

    // State register plus the per-state counters (sample index, launch phase, watchdog, abort hold)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            start_done <= 1'b0;
            watchdog   <= '0;
            abort_cnt  <= '0;
        end else begin
            state      <= state_nx;
            sample_cnt <= (state == S_FILL) ? (sample_hs ? sample_cnt + 1'b1 : sample_cnt) : '0;
            start_done <= (state == S_START);
            watchdog   <= (state == S_WAIT_INF) ? watchdog + 1'b1 : '0;
            abort_cnt  <= (state == S_ABORT) ? abort_cnt + 2'd1 : 2'd0;
        end
    end

    // Next-state decode; START spans two cycles so the pulse lands strictly after the last write
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (enable) state_nx = S_FILL;
            S_FILL: begin
                if (!enable)          state_nx = S_IDLE;
                else if (last_sample) state_nx = S_START;
            end
            S_START:    if (start_done) state_nx = S_WAIT_INF;
            S_WAIT_INF: begin
                if (cim_inference_complete) state_nx = S_RESULT;
                else if (watchdog == WD_LAST) state_nx = S_ABORT;
            end
            S_RESULT:   if (result_hs) state_nx = enable ? S_FILL : S_IDLE;
            S_ABORT:    if (abort_cnt == 2'd3) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is registered yet aligned with it
    always_comb begin
        sample_ready_d    = (state_nx == S_FILL);
        new_sleep_epoch_d = (state == S_START) && !start_done;
        cim_rst_n_d       = (state_nx != S_ABORT);
        result_valid_d    = (state_nx == S_RESULT);
        set_timeout       = (state_nx == S_ABORT);
        set_bad_stage     = capture && (cim_sleep_stage > 3'd4);
    end

    // Output registers; sticky error flags give a same-cycle set priority over err_clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_ready    <= 1'b0;
            mem_wr_en       <= 1'b0;
            mem_wr_addr     <= '0;
            mem_wr_data     <= '0;
            new_sleep_epoch <= 1'b0;
            cim_rst_n       <= 1'b0;
            result_valid    <= 1'b0;
            result_stage    <= 3'd0;
            err_timeout     <= 1'b0;
            err_bad_stage   <= 1'b0;
            epoch_count     <= 16'd0;
        end else begin
            sample_ready    <= sample_ready_d;
            mem_wr_en       <= sample_hs;
            if (sample_hs) begin
                mem_wr_addr <= sample_cnt;
                mem_wr_data <= sample_data;
            end
            new_sleep_epoch <= new_sleep_epoch_d;
            cim_rst_n       <= cim_rst_n_d;
            result_valid    <= result_valid_d;
            if (capture) begin
                result_stage <= cim_sleep_stage;
            end
            err_timeout     <= set_timeout | (err_timeout & ~err_clear);
            err_bad_stage   <= set_bad_stage | (err_bad_stage & ~err_clear);
            if (result_hs) begin
                epoch_count <= epoch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cim_epoch_sequencer.sv
// tb/tb_cim_epoch_sequencer.sv - directed plus randomized bench for cim_epoch_sequencer
module tb_cim_epoch_sequencer;

    localparam int NS = 8;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int T  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          cim_rst_n;
    logic          new_sleep_epoch;
    logic          cim_inference_complete = 1'b0;
    logic [2:0]    cim_sleep_stage = 3'd0;
    logic          result_valid;
    logic [2:0]    result_stage;
    logic          result_ready = 1'b0;
    logic          err_timeout;
    logic          err_bad_stage;
    logic          err_clear = 1'b0;
    logic [15:0]   epoch_count;

    cim_epoch_sequencer #(
        .NUM_SAMPLES(NS), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .cim_rst_n(cim_rst_n), .new_sleep_epoch(new_sleep_epoch),
        .cim_inference_complete(cim_inference_complete), .cim_sleep_stage(cim_sleep_stage),
        .result_valid(result_valid), .result_stage(result_stage), .result_ready(result_ready),
        .err_timeout(err_timeout), .err_bad_stage(err_bad_stage), .err_clear(err_clear),
        .epoch_count(epoch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_FILL = 1, M_LAUNCH = 2, M_WAIT = 3, M_RESULT = 4, M_ABORT = 5;
    int mode = M_IDLE;
    int filled = 0;
    int quiet = 0;
    int waited = 0;
    int held = 0;
    bit hs, rhs, set_to, set_bs;
    logic          exp_ready = 0, exp_wr_en = 0, exp_pulse = 0, exp_rvalid = 0;
    logic          exp_err_to = 0, exp_err_bs = 0, exp_cim_rst_n = 0;
    logic [AW-1:0] exp_wr_addr = '0;
    logic [DW-1:0] exp_wr_data = '0;
    logic [2:0]    exp_stage = '0;
    logic [15:0]   exp_epochs = '0;

    always begin
        @(posedge clk);
        hs  = exp_ready & sample_valid;
        rhs = exp_rvalid & result_ready;
        if (!rst_n) begin
            mode = M_IDLE; filled = 0;
            exp_ready = 0; exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0;
            exp_pulse = 0; exp_rvalid = 0; exp_stage = '0; exp_err_to = 0;
            exp_err_bs = 0; exp_epochs = '0; exp_cim_rst_n = 0;
        end else begin
            set_to = 0; set_bs = 0;
            exp_wr_en = 0; exp_pulse = 0; exp_cim_rst_n = 1;
            if (hs) begin
                exp_wr_en = 1; exp_wr_addr = AW'(filled); exp_wr_data = sample_data;
                filled++;
            end
            case (mode)
                M_IDLE: if (enable) begin mode = M_FILL; filled = 0; end
                M_FILL: begin
                    if (!enable) mode = M_IDLE;
                    else if (filled == NS) begin mode = M_LAUNCH; quiet = 1; end
                end
                M_LAUNCH: begin
                    if (quiet != 0) begin quiet = 0; exp_pulse = 1; end
                    else begin mode = M_WAIT; waited = 0; end
                end
                M_WAIT: begin
                    waited++;
                    if (cim_inference_complete) begin
                        exp_stage = cim_sleep_stage;
                        set_bs = (cim_sleep_stage > 4);
                        mode = M_RESULT;
                    end else if (waited == T) begin
                        mode = M_ABORT; held = 0;
                    end
                end
                M_RESULT: if (rhs) begin
                    exp_epochs++;
                    mode = enable ? M_FILL : M_IDLE;
                    filled = 0;
                end
                default: begin held++; if (held == 4) mode = M_IDLE; end
            endcase
            if (mode == M_ABORT) begin set_to = 1; exp_cim_rst_n = 0; end
            exp_ready  = (mode == M_FILL);
            exp_rvalid = (mode == M_RESULT);
            if (err_clear) begin exp_err_to = 0; exp_err_bs = 0; end
            if (set_to) exp_err_to = 1;
            if (set_bs) exp_err_bs = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("sample_ready", sample_ready, exp_ready);
            chk("mem_wr_en", mem_wr_en, exp_wr_en);
            chk("mem_wr_addr", mem_wr_addr, exp_wr_addr);
            chk("mem_wr_data", mem_wr_data, exp_wr_data);
            chk("new_sleep_epoch", new_sleep_epoch, exp_pulse);
            chk("cim_rst_n", cim_rst_n, exp_cim_rst_n);
            chk("result_valid", result_valid, exp_rvalid);
            chk("result_stage", result_stage, exp_stage);
            chk("err_timeout", err_timeout, exp_err_to);
            chk("err_bad_stage", err_bad_stage, exp_err_bs);
            chk("epoch_count", epoch_count, exp_epochs);
        end
    end

    // ---------------- event monitor ----------------
    int pulse_total = 0, last_pulse_cyc = 0, last_wr7_cyc = 0;
    int run = 0, last_run = 0, rst_runs = 0, low_start_cyc = 0;
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];

    always begin
        @(negedge clk);
        cyc++;
        if (new_sleep_epoch === 1'b1) begin pulse_total++; last_pulse_cyc = cyc; end
        if (mem_wr_en === 1'b1) begin
            wr_addr_log.push_back(mem_wr_addr);
            wr_data_log.push_back(mem_wr_data);
            if (mem_wr_addr == AW'(NS - 1)) last_wr7_cyc = cyc;
        end
        if (cim_rst_n === 1'b0) begin
            if (run == 0) low_start_cyc = cyc;
            run++;
        end else if (run != 0) begin
            last_run = run; rst_runs++; run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic send_samples(input int n, input logic [DW-1:0] base);
        int sent;
        int guard;
        sent = 0; guard = 0;
        sample_valid = 1'b1;
        sample_data  = base;
        while (sent < n && guard < 200) begin
            @(negedge clk);
            if (sample_ready === 1'b1) begin
                @(posedge clk); #1;
                sent++;
                sample_data = base + DW'(sent);
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        sample_valid = 1'b0;
        if (sent != n) chk("samples_accepted", sent, n);
    endtask

    task automatic wait_pulses(input int target);
        int g;
        g = 0;
        while (pulse_total < target && g < 100) begin settle(); g++; end
        chk("pulse_count", pulse_total, target);
    endtask

    task automatic result_handshake();
        @(posedge clk); #1 result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] outs;
        int idx, snap, g;

        // reset
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        outs = 64'({sample_ready, mem_wr_en, mem_wr_addr, mem_wr_data, new_sleep_epoch, result_valid,
                    result_stage, err_timeout, err_bad_stage, epoch_count, cim_rst_n});
        chk("reset_outputs", outs, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("cim_rst_n_before_release", cim_rst_n, 1'b0);
        @(negedge clk); chk("cim_rst_n_release", cim_rst_n, 1'b1);

        // epoch 1: continuous fill, pulse, result after 5 WAIT cycles with back-pressure
        @(posedge clk); #1 enable = 1'b1;
        send_samples(NS, 16'h0100);
        wait_pulses(1);
        chk("pulse_after_last_write", last_pulse_cyc - last_wr7_cyc, 1);
        chk("ready_low_after_fill", sample_ready, 1'b0);
        for (int i = 0; i < NS; i++) begin
            chk("fill_addr", wr_addr_log[i], i);
            chk("fill_data", wr_data_log[i], 16'h0100 + i);
        end
        repeat (5) @(posedge clk);
        #1 cim_inference_complete = 1'b1; cim_sleep_stage = 3'd3;
        @(posedge clk); #1 cim_inference_complete = 1'b0; cim_sleep_stage = 3'd0;
        @(negedge clk);
        chk("result_valid_first", result_valid, 1'b1);
        chk("result_stage_first", result_stage, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("result_stage_held", result_stage, 3'd3);
        end
        result_handshake();
        @(negedge clk);
        chk("epoch_count_one", epoch_count, 16'd1);
        chk("refill_ready", sample_ready, 1'b1);

        // epoch 2: no completion -> watchdog abort
        send_samples(NS, 16'h0200);
        wait_pulses(2);
        enable = 1'b0;
        snap = rst_runs; g = 0;
        while (rst_runs == snap && g < 80) begin settle(); g++; end
        chk("abort_run_length", last_run, 4);
        chk("abort_onset", low_start_cyc - last_pulse_cyc, T + 1);
        chk("err_timeout_set", err_timeout, 1'b1);
        chk("epoch_after_abort", epoch_count, 16'd1);
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk); chk("err_timeout_cleared", err_timeout, 1'b0);

        // epoch 3: completion on the final watchdog cycle, out-of-range stage
        @(posedge clk); #1 enable = 1'b1;
        send_samples(NS, 16'h0300);
        wait_pulses(3);
        repeat (T) @(posedge clk);
        #1 cim_inference_complete = 1'b1; cim_sleep_stage = 3'd6;
        @(posedge clk); #1 cim_inference_complete = 1'b0;
        @(negedge clk);
        chk("late_result_valid", result_valid, 1'b1);
        chk("late_result_stage", result_stage, 3'd6);
        chk("bad_stage_flag", err_bad_stage, 1'b1);
        chk("no_timeout_on_late_complete", err_timeout, 1'b0);
        result_handshake();
        @(negedge clk); chk("epoch_count_two", epoch_count, 16'd2);

        // partial epoch discarded when enable drops
        send_samples(5, 16'h0400);
        enable = 1'b0;
        repeat (3) settle();
        chk("ready_low_partial", sample_ready, 1'b0);
        chk("no_pulse_partial", pulse_total, 3);
        idx = wr_addr_log.size();
        @(posedge clk); #1 enable = 1'b1;
        send_samples(NS, 16'h0500);
        settle();
        chk("restart_addr0", wr_addr_log[idx], 0);
        chk("restart_data0", wr_data_log[idx], 16'h0500);
        chk("restart_addr7", wr_addr_log[idx + 7], 7);
        wait_pulses(4);
        repeat (2) @(posedge clk);
        #1 cim_inference_complete = 1'b1; cim_sleep_stage = 3'd1;
        @(posedge clk); #1 cim_inference_complete = 1'b0;
        result_handshake();
        @(negedge clk); chk("epoch_count_three", epoch_count, 16'd3);

        // reset in the middle of WAIT_INF, then spurious completion while idle
        send_samples(NS, 16'h0600);
        wait_pulses(5);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        outs = 64'({sample_ready, mem_wr_en, mem_wr_addr, mem_wr_data, new_sleep_epoch, result_valid,
                    result_stage, err_timeout, err_bad_stage, epoch_count, cim_rst_n});
        chk("midwait_reset_outputs", outs, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1; cim_inference_complete = 1'b1; cim_sleep_stage = 3'd5;
        repeat (3) @(posedge clk);
        #1 cim_inference_complete = 1'b0;
        @(negedge clk);
        chk("spurious_complete_ignored", result_valid, 1'b0);
        chk("spurious_no_bad_flag", err_bad_stage, 1'b0);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst_n                  = ($urandom_range(0, 399) != 0);
            enable                 = ($urandom_range(0, 19) != 0);
            sample_valid           = ($urandom_range(0, 9) < 7);
            sample_data            = DW'($urandom);
            cim_inference_complete = ($urandom_range(0, 7) == 0);
            cim_sleep_stage        = 3'($urandom);
            result_ready           = $urandom_range(0, 1) == 1;
            err_clear              = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        cim_inference_complete = 1'b0; result_ready = 1'b0; err_clear = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_epoch_sequencer.md
# cim_epoch_sequencer

SoC-side driver of the CIM control interface: buffers one sleep epoch of EEG samples into CIM intermediate-result memory, issues the `new_sleep_epoch` pulse, waits for the CIM's inference-complete indication, and returns the sleep stage to the host over a valid/ready handshake. It owns CIM reset generation, including recovery from a hung inference via a watchdog. It is the initiator counterpart of the centralized CIM control FSM.

## Interface
- NUM_SAMPLES, 3000, samples per epoch (≥2)
- DATA_W, 16, sample width
- ADDR_W, 12, CIM sample-memory address width; 2^ADDR_W ≥ NUM_SAMPLES
- TIMEOUT_CYCLES, 65535, max WAIT_INF cycles before abort (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  level; permits starting or continuing epochs
- sample_valid  in  1  host sample valid
- sample_data  in  DATA_W  host sample
- sample_ready  out  1  sequencer accepts sample
- mem_wr_en  out  1  CIM sample-memory write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- cim_rst_n  out  1  CIM synchronous reset, active-low
- new_sleep_epoch  out  1  one-cycle start pulse to CIM
- cim_inference_complete  in  1  CIM done (sampled only in WAIT_INF)
- cim_sleep_stage  in  3  CIM result, valid with inference_complete
- result_valid  out  1  stage available
- result_stage  out  3  captured stage
- result_ready  in  1  host consumes result
- err_timeout  out  1  sticky watchdog abort flag
- err_bad_stage  out  1  sticky flag: captured stage > 4
- err_clear  in  1  clears both sticky flags (one cycle)
- epoch_count  out  16  completed epochs, wraps 0xFFFF→0

## Operation
- States: IDLE, FILL, START, WAIT_INF, RESULT, ABORT.
- IDLE: sample_ready=0. enable=1 → FILL with sample counter=0.
- FILL: sample_ready=1. Each handshake (valid & ready) registers one write: mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=sample. Counter then increments. The handshake for sample NUM_SAMPLES-1 moves the FSM to START, and sample_ready drops the same cycle the last write is driven.
- enable=0 during FILL (with no handshake that cycle) → IDLE, counter=0, partial epoch discarded, no pulse. If enable falls in the same cycle as a handshake, that sample is still written, then the FSM goes to IDLE.
- START: new_sleep_epoch=1 for exactly one cycle, then WAIT_INF with watchdog=0.
- WAIT_INF: enable is ignored. On cim_inference_complete, result_stage←cim_sleep_stage and the FSM goes to RESULT. If the stage is >4, err_bad_stage is set and the stage is still delivered unchanged. The watchdog increments every WAIT_INF cycle. When watchdog=TIMEOUT_CYCLES-1 without complete → ABORT. If complete and timeout occur in the same cycle, complete wins.
- cim_inference_complete outside WAIT_INF is ignored.
- RESULT: result_valid=1, and result_stage is held stable until result_ready. On handshake: epoch_count+1, result_valid=0 next cycle, then FILL if enable=1, else IDLE.
- ABORT: err_timeout=1, cim_rst_n=0 for exactly 4 cycles, then IDLE. No result is delivered and epoch_count is unchanged.
- err_clear has lower priority than a same-cycle set (set wins).

## Timing
- Reset values: sample_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, new_sleep_epoch=0, result_valid=0, result_stage=0, err_*=0, epoch_count=0, cim_rst_n=0. State is IDLE.
- cim_rst_n rises in the first cycle after rst_n is seen high. rst_n low at any time returns all outputs to reset values on the next edge; in-flight epochs are discarded.
- All outputs are registered. mem_wr_* appear 1 cycle after the handshake cycle.
- Last handshake at cycle N: its write is at N+1, and new_sleep_epoch is at N+2 (strictly after the final write). WAIT_INF begins at N+3.
- complete sampled at cycle M: result_valid=1 at M+1.
- Timeout: with WAIT_INF entered at cycle W and no complete, err_timeout=1 and cim_rst_n=0 from W+TIMEOUT_CYCLES through W+TIMEOUT_CYCLES+3. IDLE follows.
- Back-to-back epochs: with enable held, sample_ready=1 in the cycle after the result handshake.

## Test plan
Bench parameters: NUM_SAMPLES=8, TIMEOUT_CYCLES=20.
- Reset release, enable=1, 8 samples 0x0100..0x0107 streamed continuously → writes to addresses 0..7 with matching data. Single new_sleep_epoch pulse 1 cycle after the addr-7 write. sample_ready=0 thereafter.
- In WAIT_INF, complete with stage=3 after 5 cycles → result_valid=1, result_stage=3. Hold result_ready=0 for 3 cycles (stage stable), then handshake → epoch_count=1, refill starts the next cycle.
- No complete → at cycle 20 of WAIT_INF: err_timeout=1, cim_rst_n low for exactly 4 cycles, IDLE. epoch_count unchanged. err_clear → err_timeout=0.
- Complete asserted on the final watchdog cycle → result delivered, err_timeout stays 0. Stage=6 → err_bad_stage=1, result_stage=6.
- enable dropped after 5 samples → IDLE, no pulse. Re-enable → writes restart at address 0.
- rst_n asserted mid-WAIT_INF → all outputs at reset values, including cim_rst_n=0. Spurious complete in IDLE → ignored.
